// File: rtl/center_of_mass.sv
// Per-frame centroid of thresholded pixels using two parallel 32-step restoring dividers.
// Optional CENTER_OF_MASS_MIN_PIXELS_EN suppresses updates for frames below MIN_PIXELS.
module center_of_mass #(
   parameter int unsigned H_ACTIVE   = 1280,
   parameter int unsigned V_ACTIVE   = 720,
   parameter int unsigned MIN_PIXELS = 16
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic [10:0] x_in,
   input  logic [9:0]  y_in,
   input  logic        valid_in,
   input  logic        tabulate_in,
   output logic [10:0] x_out,
   output logic [9:0]  y_out,
   output logic        valid_out,
   output logic        busy_out
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIVIDE = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t      state_r;
   state_t      next_state_s;

   logic [31:0] sum_x_r;
   logic [31:0] sum_y_r;
   logic [19:0] count_r;

   logic [31:0] quo_x_r;
   logic [31:0] quo_y_r;
   logic [19:0] rem_x_r;
   logic [19:0] rem_y_r;
   logic [19:0] div_cnt_r;
   logic [4:0]  iter_r;

   logic        pix_s;
   logic        close_s;
   logic        frame_ok_s;
   logic [31:0] sum_x_copy_s;
   logic [31:0] sum_y_copy_s;
   logic [19:0] cnt_copy_s;

   logic [10:0] x_r;
   logic [9:0]  y_r;
   logic        valid_r;
   logic        busy_r;
   logic [10:0] x_nx_s;
   logic [9:0]  y_nx_s;
   logic        valid_nx_s;
   logic        busy_nx_s;

   // One restoring step: returns {remainder, quotient/dividend shift register}.
   function automatic logic [51:0] div_step(input logic [19:0] rem,
                                            input logic [31:0] quo,
                                            input logic [19:0] dvs);
      logic [20:0] trial;
      logic [19:0] rem_n;
      logic        q_bit;
      trial = {rem, quo[31]};
      if (trial >= {1'b0, dvs}) begin
         rem_n = 20'(trial - {1'b0, dvs});
         q_bit = 1'b1;
      end else begin
         rem_n = trial[19:0];
         q_bit = 1'b0;
      end
      return {rem_n, quo[30:0], q_bit};
   endfunction

   assign pix_s   = valid_in && (x_in < 11'(H_ACTIVE)) && (y_in < 10'(V_ACTIVE));
   assign close_s = tabulate_in && (state_r == IDLE);

   // Frame totals as seen by the divider, including a pixel arriving with the strobe.
   always_comb begin
      sum_x_copy_s = sum_x_r + (pix_s ? {21'd0, x_in} : 32'd0);
      sum_y_copy_s = sum_y_r + (pix_s ? {22'd0, y_in} : 32'd0);
      cnt_copy_s   = count_r + {19'd0, pix_s};
   end

`ifdef CENTER_OF_MASS_MIN_PIXELS_EN
   assign frame_ok_s = (cnt_copy_s != 20'd0) && (cnt_copy_s >= 20'(MIN_PIXELS));
`else
   logic unused_min_pixels_s;
   assign unused_min_pixels_s = (MIN_PIXELS != 32'd0);
   assign frame_ok_s = (cnt_copy_s != 20'd0);
`endif

   // Accumulators: cleared on frame close, otherwise sum in-range pixels.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         sum_x_r <= 32'd0;
         sum_y_r <= 32'd0;
         count_r <= 20'd0;
      end else if (close_s) begin
         sum_x_r <= 32'd0;
         sum_y_r <= 32'd0;
         count_r <= 20'd0;
      end else if (pix_s) begin
         sum_x_r <= sum_x_r + {21'd0, x_in};
         sum_y_r <= sum_y_r + {22'd0, y_in};
         count_r <= count_r + 20'd1;
      end else begin
         sum_x_r <= sum_x_r;
         sum_y_r <= sum_y_r;
         count_r <= count_r;
      end
   end

   // Divider datapath: load on frame close, one quotient bit per cycle in DIVIDE.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         quo_x_r   <= 32'd0;
         quo_y_r   <= 32'd0;
         rem_x_r   <= 20'd0;
         rem_y_r   <= 20'd0;
         div_cnt_r <= 20'd0;
         iter_r    <= 5'd0;
      end else if (close_s) begin
         quo_x_r   <= sum_x_copy_s;
         quo_y_r   <= sum_y_copy_s;
         rem_x_r   <= 20'd0;
         rem_y_r   <= 20'd0;
         div_cnt_r <= cnt_copy_s;
         iter_r    <= 5'd0;
      end else if (state_r == DIVIDE) begin
         {rem_x_r, quo_x_r} <= div_step(rem_x_r, quo_x_r, div_cnt_r);
         {rem_y_r, quo_y_r} <= div_step(rem_y_r, quo_y_r, div_cnt_r);
         iter_r             <= iter_r + 5'd1;
      end else begin
         quo_x_r   <= quo_x_r;
         quo_y_r   <= quo_y_r;
         rem_x_r   <= rem_x_r;
         rem_y_r   <= rem_y_r;
         div_cnt_r <= div_cnt_r;
         iter_r    <= iter_r;
      end
   end

   // State register.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (tabulate_in && frame_ok_s) begin
               next_state_s = DIVIDE;
            end else begin
               next_state_s = IDLE;
            end
         end
         DIVIDE: begin
            if (iter_r == 5'd31) begin
               next_state_s = DONE;
            end else begin
               next_state_s = DIVIDE;
            end
         end
         DONE:    next_state_s = IDLE;
         default: next_state_s = IDLE;
      endcase
   end

   // Output decode; values are registered below so every port is a flop.
   always_comb begin
      x_nx_s     = x_r;
      y_nx_s     = y_r;
      valid_nx_s = 1'b0;
      busy_nx_s  = (next_state_s != IDLE);
      case (state_r)
         DONE: begin
            x_nx_s     = quo_x_r[10:0];
            y_nx_s     = quo_y_r[9:0];
            valid_nx_s = 1'b1;
         end
         IDLE:    valid_nx_s = 1'b0;
         DIVIDE:  valid_nx_s = 1'b0;
         default: valid_nx_s = 1'b0;
      endcase
   end

   // Output registers.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         x_r     <= 11'd0;
         y_r     <= 10'd0;
         valid_r <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         x_r     <= x_nx_s;
         y_r     <= y_nx_s;
         valid_r <= valid_nx_s;
         busy_r  <= busy_nx_s;
      end
   end

   assign x_out     = x_r;
   assign y_out     = y_r;
   assign valid_out = valid_r;
   assign busy_out  = busy_r;

endmodule

// File: tb/tb_center_of_mass.sv
// Directed self-checking bench for center_of_mass.
module tb_center_of_mass;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [10:0] x_in = 11'd0;
   logic [9:0]  y_in = 10'd0;
   logic        valid_in = 1'b0;
   logic        tabulate_in = 1'b0;
   logic [10:0] x_out;
   logic [9:0]  y_out;
   logic        valid_out;
   logic        busy_out;

   int errors = 0;
   int checks = 0;

   center_of_mass dut (
      .clk_in      (clk),
      .rst_n_in    (rst_n),
      .x_in        (x_in),
      .y_in        (y_in),
      .valid_in    (valid_in),
      .tabulate_in (tabulate_in),
      .x_out       (x_out),
      .y_out       (y_out),
      .valid_out   (valid_out),
      .busy_out    (busy_out)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pixel(input int x, input int y);
      x_in = 11'(x);
      y_in = 10'(y);
      valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
   endtask

   task automatic tabulate();
      tabulate_in = 1'b1;
      tick();
      tabulate_in = 1'b0;
   endtask

   // Cycle index (1 = cycle right after the current point) of the first valid_out, or -1.
   task automatic wait_valid(input int budget, output int n);
      n = -1;
      for (int i = 1; i <= budget; i++) begin
         if (valid_out === 1'b1) begin
            n = i;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      checks++; if (x_out !== 11'd0) begin errors++; $display("FAIL reset_x got=%0d exp=0", x_out); end
      checks++; if (y_out !== 10'd0) begin errors++; $display("FAIL reset_y got=%0d exp=0", y_out); end
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
      checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_out); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single_pixel();
      int first_valid;
      int busy_cnt;
      int valid_cnt;
      first_valid = -1;
      busy_cnt = 0;
      valid_cnt = 0;
      pixel(100, 50);
      tabulate();
      for (int n = 1; n <= 45; n++) begin
         if (busy_out === 1'b1) busy_cnt++;
         if (valid_out === 1'b1) begin
            valid_cnt++;
            if (first_valid < 0) first_valid = n;
         end
         tick();
      end
      checks++; if (first_valid !== 34) begin errors++; $display("FAIL single_latency got=%0d exp=34", first_valid); end
      checks++; if (busy_cnt !== 33) begin errors++; $display("FAIL single_busy_cycles got=%0d exp=33", busy_cnt); end
      checks++; if (valid_cnt !== 1) begin errors++; $display("FAIL single_valid_pulses got=%0d exp=1", valid_cnt); end
      checks++; if (x_out !== 11'd100) begin errors++; $display("FAIL single_x got=%0d exp=100", x_out); end
      checks++; if (y_out !== 10'd50) begin errors++; $display("FAIL single_y got=%0d exp=50", y_out); end
   endtask

   task automatic test_floor();
      int n;
      pixel(0, 0);
      pixel(3, 0);
      pixel(0, 4);
      pixel(2, 1);
      tabulate();
      wait_valid(60, n);
      checks++; if (n !== 34) begin errors++; $display("FAIL floor_latency got=%0d exp=34", n); end
      checks++; if (x_out !== 11'd1) begin errors++; $display("FAIL floor_x got=%0d exp=1", x_out); end
      checks++; if (y_out !== 10'd1) begin errors++; $display("FAIL floor_y got=%0d exp=1", y_out); end
      tick();
   endtask

   // Edge coordinates kept, out-of-range dropped, pixel coincident with tabulate counted.
   task automatic test_range();
      int n;
      pixel(1279, 719);
      pixel(1280, 0);
      pixel(0, 720);
      pixel(2047, 1023);
      x_in = 11'd1;
      y_in = 10'd1;
      valid_in = 1'b1;
      tabulate_in = 1'b1;
      tick();
      valid_in = 1'b0;
      tabulate_in = 1'b0;
      wait_valid(60, n);
      checks++; if (n !== 34) begin errors++; $display("FAIL range_latency got=%0d exp=34", n); end
      checks++; if (x_out !== 11'd640) begin errors++; $display("FAIL range_x got=%0d exp=640", x_out); end
      checks++; if (y_out !== 10'd360) begin errors++; $display("FAIL range_y got=%0d exp=360", y_out); end
      tick();
   endtask

   task automatic test_empty();
      int valid_cnt;
      int busy_cnt;
      valid_cnt = 0;
      busy_cnt = 0;
      tabulate();
      for (int n = 1; n <= 45; n++) begin
         if (valid_out === 1'b1) valid_cnt++;
         if (busy_out === 1'b1) busy_cnt++;
         tick();
      end
      checks++; if (valid_cnt !== 0) begin errors++; $display("FAIL empty_valid got=%0d exp=0", valid_cnt); end
      checks++; if (busy_cnt !== 0) begin errors++; $display("FAIL empty_busy got=%0d exp=0", busy_cnt); end
      checks++; if (x_out !== 11'd640) begin errors++; $display("FAIL empty_hold_x got=%0d exp=640", x_out); end
      checks++; if (y_out !== 10'd360) begin errors++; $display("FAIL empty_hold_y got=%0d exp=360", y_out); end
   endtask

   task automatic test_back_to_back();
      int n;
      pixel(10, 20);
      tabulate();
      repeat (9) tick();
      x_in = 11'd30;
      y_in = 10'd40;
      valid_in = 1'b1;
      tabulate_in = 1'b1;
      tick();
      tabulate_in = 1'b0;
      x_in = 11'd50;
      y_in = 10'd60;
      tick();
      valid_in = 1'b0;
      wait_valid(40, n);
      checks++; if (n !== 23) begin errors++; $display("FAIL b2b_first_latency got=%0d exp=23", n); end
      checks++; if (x_out !== 11'd10) begin errors++; $display("FAIL b2b_first_x got=%0d exp=10", x_out); end
      checks++; if (y_out !== 10'd20) begin errors++; $display("FAIL b2b_first_y got=%0d exp=20", y_out); end
      tick();
      tabulate();
      wait_valid(60, n);
      checks++; if (n !== 34) begin errors++; $display("FAIL b2b_second_latency got=%0d exp=34", n); end
      checks++; if (x_out !== 11'd40) begin errors++; $display("FAIL b2b_second_x got=%0d exp=40", x_out); end
      checks++; if (y_out !== 10'd50) begin errors++; $display("FAIL b2b_second_y got=%0d exp=50", y_out); end
      tick();
   endtask

   task automatic test_reset_mid_divide();
      int valid_cnt;
      int n;
      valid_cnt = 0;
      pixel(7, 9);
      tabulate();
      repeat (5) tick();
      rst_n = 1'b0;
      #2;
      checks++; if (x_out !== 11'd0) begin errors++; $display("FAIL rstmid_x got=%0d exp=0", x_out); end
      checks++; if (y_out !== 10'd0) begin errors++; $display("FAIL rstmid_y got=%0d exp=0", y_out); end
      checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy_out); end
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 45; i++) begin
         if (valid_out === 1'b1) valid_cnt++;
         tick();
      end
      checks++; if (valid_cnt !== 0) begin errors++; $display("FAIL rstmid_no_valid got=%0d exp=0", valid_cnt); end
      pixel(200, 100);
      pixel(202, 104);
      tabulate();
      wait_valid(60, n);
      checks++; if (n !== 34) begin errors++; $display("FAIL rstmid_after_latency got=%0d exp=34", n); end
      checks++; if (x_out !== 11'd201) begin errors++; $display("FAIL rstmid_after_x got=%0d exp=201", x_out); end
      checks++; if (y_out !== 10'd102) begin errors++; $display("FAIL rstmid_after_y got=%0d exp=102", y_out); end
      tick();
   endtask

`ifdef CENTER_OF_MASS_MIN_PIXELS_EN
   task automatic test_min_pixels();
      int valid_cnt;
      int n;
      valid_cnt = 0;
      for (int i = 0; i < 15; i++) pixel(640, 360);
      tabulate();
      for (int i = 0; i < 45; i++) begin
         if (valid_out === 1'b1) valid_cnt++;
         tick();
      end
      checks++; if (valid_cnt !== 0) begin errors++; $display("FAIL min15_valid got=%0d exp=0", valid_cnt); end
      checks++; if (x_out !== 11'd201) begin errors++; $display("FAIL min15_hold_x got=%0d exp=201", x_out); end
      for (int i = 0; i < 16; i++) pixel(640, 360);
      tabulate();
      wait_valid(60, n);
      checks++; if (n !== 34) begin errors++; $display("FAIL min16_latency got=%0d exp=34", n); end
      checks++; if (x_out !== 11'd640) begin errors++; $display("FAIL min16_x got=%0d exp=640", x_out); end
      checks++; if (y_out !== 10'd360) begin errors++; $display("FAIL min16_y got=%0d exp=360", y_out); end
      tick();
   endtask
`else
   task automatic test_min_pixels();
      int n;
      for (int i = 0; i < 15; i++) pixel(640, 360);
      tabulate();
      wait_valid(60, n);
      checks++; if (n !== 34) begin errors++; $display("FAIL small_frame_latency got=%0d exp=34", n); end
      checks++; if (x_out !== 11'd640) begin errors++; $display("FAIL small_frame_x got=%0d exp=640", x_out); end
      checks++; if (y_out !== 10'd360) begin errors++; $display("FAIL small_frame_y got=%0d exp=360", y_out); end
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_single_pixel();
      test_floor();
      test_range();
      test_empty();
      test_back_to_back();
      test_reset_mid_divide();
      test_min_pixels();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
